gate_tt_checker: RTL
====================

Name: gate_tt_checker

Overview:
Self-checking truth-table sequencer wrapped around the decoder-based logic-gate block. It drives that block's a/b inputs through all four combinations and samples its seven gate outputs after a settle interval. Each sample is compared against a golden truth table, and the block accumulates a per-gate fail mask and a mismatch count. It is used as a built-in test harness stage, both upstream (stimulus) and downstream (checker) of the gate block.

Parameters:
SETTLE_CYCLES, 1, cycles a/b are held before sampling; legal range 1..15.
ROUNDS, 1, full 4-combination sweeps per run; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  run request; sampled in IDLE only
a  output  1  stimulus to gate block, registered; equals combo[1]
b  output  1  stimulus to gate block, registered; equals combo[0]
and_g  input  1  gate block result
or_gate  input  1  gate block result
not_gate  input  1  gate block result
nor_g  input  1  gate block result
nand_g  input  1  gate block result
xor_g  input  1  gate block result
xnor_g  input  1  gate block result
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at end of run
pass  output  1  1 when last run had fail_mask==0; valid from done, held until next start
fail_mask  output  7  sticky per-gate mismatch; bit order [0]and [1]or [2]not [3]nor [4]nand [5]xor [6]xnor
err_count  output  4  number of samples with any mismatch; saturates at 15

Behaviour:
- Reset, asynchronous: state=IDLE, a=b=0, busy=done=pass=0, fail_mask=0, err_count=0, combo=0, round=0, settle counter=0. This applies mid-run too: the run is aborted and no done is issued.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 clears fail_mask, err_count, pass, combo, round and the settle counter.
  - It sets busy=1 and moves to SETTLE with a=b=0.
  - start=0 keeps the state in IDLE.
- SETTLE: the counter runs SETTLE_CYCLES cycles, then the state moves to SAMPLE. a and b stay stable throughout.
- SAMPLE (one cycle):
  - Golden values: and=a&b, or=a|b, not=~a, nor=~(a|b), nand=~(a&b), xor=a^b, xnor=~(a^b).
  - Each mismatching bit is ORed into fail_mask.
  - If any bit mismatches, err_count increments by 1, saturating at 15 with no wrap.
  - If combo<3: combo+1 is loaded (a,b update on the same edge), the counter is cleared, and the state goes to SETTLE.
  - If combo==3 and round<ROUNDS-1: combo=0, round+1, and the state goes to SETTLE.
  - If combo==3 and round==ROUNDS-1: the state goes to DONE.
- DONE (one cycle):
  - done=1, pass=(fail_mask==0), busy=0.
  - a=b=0 on exit; the next state is IDLE.
  - pass, fail_mask and err_count hold until the next accepted start.
- start while busy, or while in DONE, is ignored and not queued.
- Sequence order per round: (a,b)=00, 01, 10, 11.
- Latency: start is sampled at edge 0.
  - a/b first valid after edge 0.
  - Final SAMPLE at edge 4*ROUNDS*(SETTLE_CYCLES+1).
  - done is high for the cycle after edge 4*ROUNDS*(SETTLE_CYCLES+1)+1.
  - With defaults, done is high after edge 9.
- The gate inputs are treated as combinational from a/b. No synchronisers.

Test Plan:
1. Correct gate block, defaults, start pulse at edge 0 -> a/b sequence 00,01,10,11 each held 2 cycles. done is high 1 cycle after edge 9, with pass=1, fail_mask=7'h00, err_count=0, and busy high for edges 1..8.
2. xor_g stuck at 0 -> mismatches at combos 01 and 10. fail_mask=7'b0100000, err_count=2, pass=0.
3. not_gate wired to b instead of ~a -> mismatches at 00 and 11. fail_mask=7'b0000100, err_count=2.
4. ROUNDS=5, all seven outputs inverted -> 20 mismatching samples. err_count saturates at 15, fail_mask=7'h7F, done after edge 41.
5. rst asserted in the middle of the combo-10 SETTLE, asynchronously -> outputs zero immediately and no done pulse. A new start then runs a full clean sweep with pass=1.
6. start held high continuously through a run, and start pulsed in DONE -> neither restarts the run. After returning to IDLE, start=1 begins a new run and clears fail_mask/err_count on that edge.

Source files
------------

// File: rtl/gate_tt_checker.sv
// Truth-table sequencer and checker for the seven-output logic-gate block.
// Sweeps a/b through 00,01,10,11, samples after a settle delay, scores each sample.
module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ROUNDS        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_g,
  input  logic       or_gate,
  input  logic       not_gate,
  input  logic       nor_g,
  input  logic       nand_g,
  input  logic       xor_g,
  input  logic       xnor_g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SET_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] combo_q;
  logic [1:0] combo_nx;
  logic [3:0] round_q;
  logic [3:0] cnt_q;
  logic       settle_last;
  logic       last_combo;
  logic       last_round;
  logic [6:0] gold;
  logic [6:0] obs;
  logic [6:0] miss;

  // Golden values come from the registered stimulus, not from combo.
  assign gold = {~(a ^ b), a ^ b, ~(a & b),
                 ~(a | b), ~a, a | b, a & b};
  assign obs  = {xnor_g, xor_g, nand_g, nor_g,
                 not_gate, or_gate, and_g};
  assign miss = obs ^ gold;

  assign combo_nx    = combo_q + 2'd1;
  assign settle_last = (cnt_q == SET_LAST);
  assign last_combo  = (combo_q == 2'd3);
  assign last_round  = (round_q == RND_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = SETTLE;
      SETTLE: if (settle_last) state_d = SAMPLE;
      SAMPLE: begin
        if (last_combo && last_round)
          state_d = DONE;
        else
          state_d = SETTLE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 7'h00;
      err_count <= 4'd0;
      combo_q   <= 2'd0;
      round_q   <= 4'd0;
      cnt_q     <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            fail_mask <= 7'h00;
            err_count <= 4'd0;
            pass      <= 1'b0;
            combo_q   <= 2'd0;
            round_q   <= 4'd0;
            cnt_q     <= 4'd0;
            busy      <= 1'b1;
            a         <= 1'b0;
            b         <= 1'b0;
          end
        end
        SETTLE: begin
          cnt_q <= settle_last ? 4'd0 : cnt_q + 4'd1;
        end
        SAMPLE: begin
          fail_mask <= fail_mask | miss;
          if ((|miss) && (err_count != 4'd15))
            err_count <= err_count + 4'd1;
          cnt_q <= 4'd0;
          if (!last_combo) begin
            combo_q <= combo_nx;
            a       <= combo_nx[1];
            b       <= combo_nx[0];
          end else if (!last_round) begin
            combo_q <= 2'd0;
            round_q <= round_q + 4'd1;
            a       <= 1'b0;
            b       <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= (fail_mask == 7'h00);
          a    <= 1'b0;
          b    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
